// File: rtl/sample_packer.sv
// Sample-domain capture back-end: packs SDR/DDR lane samples into DATA_W-bit words for the sample FIFO.
// Optional per-bit deglitch filter enabled by defining SAMPLE_PACKER_DEGLITCH_EN.
module sample_packer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              sample_clk,
  input  logic              sample_rst,
  input  logic              sample_en,
  input  logic [1:0]        mode,
  input  logic              test_mode,
  input  logic [DATA_W-1:0] din_pos,
  input  logic [DATA_W-1:0] din_neg,
  input  logic              wr_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  // Place the {neg, pos} lane slice of the current cycle at slice position k.
  function automatic logic [DATA_W-1:0] place_slice(
    input logic [1:0]        m,
    input logic [1:0]        k,
    input logic [DATA_W-1:0] p,
    input logic [DATA_W-1:0] n
  );
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] s;
    int                lane;
    lane = DATA_W >> m;
    ones = {DATA_W{1'b1}};
    mask = ones >> (DATA_W - lane);
    if (m == 2'd0) begin
      s = p;
    end else begin
      s = (p & mask) | ((n & mask) << lane);
    end
    return s << (2 * lane * int'(k));
  endfunction

  logic [DATA_W-1:0] pos_s;
  logic [DATA_W-1:0] neg_s;
  logic              en_s;

`ifdef SAMPLE_PACKER_DEGLITCH_EN
  logic [DATA_W-1:0] pos_prev_r;
  logic [DATA_W-1:0] neg_prev_r;
  logic [DATA_W-1:0] pos_filt_r;
  logic [DATA_W-1:0] neg_filt_r;
  logic              en_d_r;

  // A bit only follows the raw stream once two consecutive samples agree.
  always_ff @(posedge sample_clk or posedge sample_rst) begin
    if (sample_rst) begin
      pos_prev_r <= '0;
      neg_prev_r <= '0;
      pos_filt_r <= '0;
      neg_filt_r <= '0;
      en_d_r     <= 1'b0;
    end else begin
      pos_prev_r <= din_pos;
      neg_prev_r <= din_neg;
      pos_filt_r <= (~(din_pos ^ pos_prev_r) & din_pos) | ((din_pos ^ pos_prev_r) & pos_filt_r);
      neg_filt_r <= (~(din_neg ^ neg_prev_r) & din_neg) | ((din_neg ^ neg_prev_r) & neg_filt_r);
      en_d_r     <= sample_en;
    end
  end

  assign pos_s = pos_filt_r;
  assign neg_s = neg_filt_r;
  assign en_s  = en_d_r;
`else
  assign pos_s = din_pos;
  assign neg_s = din_neg;
  assign en_s  = sample_en;
`endif

  logic [1:0]        idx_r;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] test_cnt_r;

  logic [1:0]        idx_eff_s;
  logic [1:0]        last_idx_s;
  logic [1:0]        idx_next_s;
  logic [DATA_W-1:0] word_s;
  logic              complete_s;
  logic              write_s;
  logic              drop_s;

  // Slice assembly, word completion and next pack index.
  always_comb begin
    idx_eff_s  = (mode != mode_r) ? 2'd0 : idx_r;
    last_idx_s = 2'd0;
    case (mode)
      2'd2:    last_idx_s = 2'd1;
      2'd3:    last_idx_s = 2'd3;
      default: last_idx_s = 2'd0;
    endcase
    if (idx_eff_s == 2'd0) begin
      word_s = place_slice(mode, idx_eff_s, pos_s, neg_s);
    end else begin
      word_s = acc_r | place_slice(mode, idx_eff_s, pos_s, neg_s);
    end
    complete_s = en_s && (idx_eff_s == last_idx_s);
    write_s    = complete_s && !wr_full;
    drop_s     = complete_s && wr_full;
    if (!en_s || complete_s) begin
      idx_next_s = 2'd0;
    end else begin
      idx_next_s = idx_eff_s + 2'd1;
    end
  end

  // Packing state; a disabled cycle discards any partial word.
  always_ff @(posedge sample_clk or posedge sample_rst) begin
    if (sample_rst) begin
      idx_r  <= 2'd0;
      mode_r <= 2'd0;
      acc_r  <= '0;
    end else begin
      idx_r  <= idx_next_s;
      mode_r <= mode;
      acc_r  <= en_s ? word_s : '0;
    end
  end

  // Test counter only advances on words that actually reach the FIFO.
  always_ff @(posedge sample_clk or posedge sample_rst) begin
    if (sample_rst) begin
      test_cnt_r <= '0;
    end else if (!en_s) begin
      test_cnt_r <= '0;
    end else if (write_s && test_mode) begin
      test_cnt_r <= test_cnt_r + DATA_ONE;
    end else begin
      test_cnt_r <= test_cnt_r;
    end
  end

  // FIFO write port and written-word count.
  always_ff @(posedge sample_clk or posedge sample_rst) begin
    if (sample_rst) begin
      wr_en    <= 1'b0;
      wr_data  <= '0;
      word_cnt <= '0;
    end else if (write_s) begin
      wr_en    <= 1'b1;
      wr_data  <= test_mode ? test_cnt_r : word_s;
      word_cnt <= word_cnt + CNT_ONE;
    end else begin
      wr_en    <= 1'b0;
    end
  end

  // Overflow accounting; a drop in the same cycle as a clear takes priority.
  always_ff @(posedge sample_clk or posedge sample_rst) begin
    if (sample_rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_s) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_cnt <= CNT_ONE;
      end else if (drop_cnt == CNT_MAX) begin
        drop_cnt <= drop_cnt;
      end else begin
        drop_cnt <= drop_cnt + CNT_ONE;
      end
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_sample_packer.sv
// Scoreboard bench for sample_packer (DATA_W=16): expected words with their arrival cycle are
// queued by the driver and matched by an independent monitor on the falling edge.
module tb_sample_packer;

  localparam int DW = 16;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          sample_clk = 1'b0;
  logic          sample_rst = 1'b1;
  logic          sample_en  = 1'b0;
  logic [1:0]    mode       = 2'd0;
  logic          test_mode  = 1'b0;
  logic [DW-1:0] din_pos    = '0;
  logic [DW-1:0] din_neg    = '0;
  logic          wr_full    = 1'b0;
  logic          ovf_clr    = 1'b0;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          overflow;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] word_cnt;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  sample_packer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .sample_clk (sample_clk),
    .sample_rst (sample_rst),
    .sample_en  (sample_en),
    .mode       (mode),
    .test_mode  (test_mode),
    .din_pos    (din_pos),
    .din_neg    (din_neg),
    .wr_full    (wr_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .drop_cnt   (drop_cnt),
    .word_cnt   (word_cnt)
  );

  always #5 sample_clk = ~sample_clk;

  always @(posedge sample_clk) cyc <= cyc + 1;

  // Monitor: every FIFO write must match the oldest expected word and its cycle.
  always @(negedge sample_clk) begin
    exp_t e;
    if (!sample_rst && wr_en) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h required=no_write cyc=%0d", wr_data, cyc);
      end else begin
        e = sb_q.pop_front();
        if (wr_data !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL write_word actual=%0h@%0d required=%0h@%0d", wr_data, cyc, e.data, e.cyc);
        end
      end
    end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_write actual=none required=%0h@%0d", sb_q[0].data, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] m, input logic [DW-1:0] p,
                      input logic [DW-1:0] n, input logic full, input logic tm,
                      input logic clr, input logic push, input logic [DW-1:0] exp);
    exp_t e;
    @(negedge sample_clk);
    sample_en = en;
    mode      = m;
    din_pos   = p;
    din_neg   = n;
    wr_full   = full;
    test_mode = tm;
    ovf_clr   = clr;
    if (push) begin
      e.data = exp;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int k, input logic [1:0] m);
    for (int i = 0; i < k; i++) step(1'b0, m, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    repeat (2) @(negedge sample_clk);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_word_cnt", 32'(word_cnt), 32'h0);
    sample_rst = 1'b0;
    idle(1, 2'd0);

    // Mode 0: one word per enabled cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 16'hA5A5, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5);
    idle(2, 2'd1);
    chk("m0_word_cnt", 32'(word_cnt), 32'd4);

    // Mode 1: {neg[7:0], pos[7:0]} every cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3412);
    idle(2, 2'd2);
    chk("m1_word_cnt", 32'(word_cnt), 32'd7);

    // Mode 2: two 8-bit slices per word, oldest in the LSBs.
    step(1'b1, 2'd2, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd2, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4321);
    step(1'b1, 2'd2, 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd2, 16'h0007, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8765);
    idle(2, 2'd3);
    chk("m2_word_cnt", 32'(word_cnt), 32'd9);

    // Mode 3: four 4-bit slices; upper input bits must be ignored.
    step(1'b1, 2'd3, 16'hFFF1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd3, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd3, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd3, 16'hAAA0, 16'h5557, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC639);
    idle(2, 2'd0);
    chk("m3_word_cnt", 32'(word_cnt), 32'd10);

    // Overflow: three words dropped, then cleared.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 16'h1111, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(2, 2'd0);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("ovf_word_cnt", 32'(word_cnt), 32'd10);
    chk("ovf_wr_data_hold", 32'(wr_data), 32'hC639);
    step(1'b0, 2'd0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(2, 2'd0);
    chk("clr_flag", 32'(overflow), 32'h0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);

    // Drop and clear in the same cycle: the drop wins.
    step(1'b1, 2'd0, 16'h2222, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(2, 2'd0);
    chk("drop_clr_flag", 32'(overflow), 32'h1);
    chk("drop_clr_cnt", 32'(drop_cnt), 32'd1);
    step(1'b0, 2'd0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(1, 2'd0);

    // Test mode: full on cycles 3-4; counter holds so the written sequence has no gaps.
    step(1'b1, 2'd0, 16'hDEAD, '0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
    step(1'b1, 2'd0, 16'hDEAD, '0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1);
    step(1'b1, 2'd0, 16'hDEAD, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 2'd0, 16'hDEAD, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 2'd0, 16'hDEAD, '0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
    step(1'b1, 2'd0, 16'hDEAD, '0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3);
    step(1'b1, 2'd0, 16'hDEAD, '0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd4);
    idle(2, 2'd3);
    chk("tm_overflow", 32'(overflow), 32'h1);
    chk("tm_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("tm_word_cnt", 32'(word_cnt), 32'd15);

    // Mode 3 reset after two slices: immediate clear, then four fresh slices.
    step(1'b1, 2'd3, 16'h000F, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd3, 16'h000F, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge sample_clk);
    sample_en  = 1'b0;
    sample_rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'h0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'h0);
    repeat (2) @(negedge sample_clk);
    sample_rst = 1'b0;
    step(1'b1, 2'd3, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd3, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd3, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd3, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC639);
    idle(3, 2'd3);
    chk("post_rst_word_cnt", 32'(word_cnt), 32'd1);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
